// File: rtl/sipo_framer_if.sv
// Bus bundle for sipo_framer: serial input side plus the parallel word output slot.
interface sipo_framer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             I;
    logic             I_VALID;
    logic             SYNC;
    logic             O_READY;
    logic             CLR_OVERRUN;
    logic [WIDTH-1:0] SHIFT;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             OVERRUN;

    // Serial source and word consumer.
    modport master (
        output I, I_VALID, SYNC, O_READY, CLR_OVERRUN,
        input  SHIFT, O, O_VALID, OVERRUN
    );

    // The framer itself.
    modport slave (
        input  I, I_VALID, SYNC, O_READY, CLR_OVERRUN,
        output SHIFT, O, O_VALID, OVERRUN
    );
endinterface

// File: rtl/sipo_framer.sv
// Serial-to-parallel deserialiser with SYNC frame alignment and a
// valid/ready output register that flags dropped words as OVERRUN.
module sipo_framer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic         CLK,
    input logic         RESET,
    sipo_framer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_o;
    logic [CW-1:0]    r_cnt;
    logic             r_o_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_complete;
    logic             w_slot_free;

    // Shift direction picks which end the first bit of a frame ends up at.
    if (MSB_FIRST) begin : g_msb
        assign w_shift_next = {r_shift[WIDTH-2:0], bus.I};
    end else begin : g_lsb
        assign w_shift_next = {bus.I, r_shift[WIDTH-1:1]};
    end

    // A SYNC bit always restarts the frame, so it can never complete one.
    assign w_complete  = bus.I_VALID && !bus.SYNC && (r_cnt == CW'(WIDTH - 1));
    assign w_slot_free = !r_o_valid || bus.O_READY;

    // Shift register and frame bit counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (bus.I_VALID) begin
            r_shift <= w_shift_next;
            if (bus.SYNC) begin
                r_cnt <= CW'(1);
            end else if (w_complete) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (bus.SYNC) begin
            r_cnt <= '0;
        end
    end

    // Output slot: load on completion if free, drop and flag if busy, else drain on accept.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete && w_slot_free) begin
                r_o       <= w_shift_next;
                r_o_valid <= 1'b1;
            end else if (!w_complete && r_o_valid && bus.O_READY) begin
                r_o_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_complete && !w_slot_free) begin
                r_overrun <= 1'b1;
            end else if (bus.CLR_OVERRUN) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.SHIFT   = r_shift;
    assign bus.O       = r_o;
    assign bus.O_VALID = r_o_valid;
    assign bus.OVERRUN = r_overrun;
endmodule

// File: tb/tb_sipo_framer.sv
// Bench for sipo_framer: two instances (MSB-first and LSB-first) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_sipo_framer;
    localparam int unsigned W = 8;

    logic CLK;
    logic RESET;

    sipo_framer_if #(.WIDTH(W)) if_m ();
    sipo_framer_if #(.WIDTH(W)) if_l ();

    sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if_m.slave)
    );

    sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if_l.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: valid-bit history, bits of the open frame, and per-instance output slot.
    bit           hist[$];
    bit           frame[$];
    logic [W-1:0] m_o[2];
    bit           m_v[2];
    bit           m_ovr[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Word built from the open frame; index 0 is the first bit received.
    function automatic logic [W-1:0] frame_word(input bit msb);
        logic [W-1:0] w = '0;
        for (int k = 0; k < frame.size(); k++) begin
            if (msb) w[W-1-k] = frame[k];
            else     w[k]     = frame[k];
        end
        return w;
    endfunction

    // SHIFT is just the last W valid bits (zeros before reset history), placed by direction.
    function automatic logic [W-1:0] shift_model(input bit msb);
        logic [W-1:0] s = '0;
        int n = hist.size();
        for (int k = 0; k < n; k++) begin
            if (msb) s[k]     = hist[n-1-k];
            else     s[W-1-k] = hist[n-1-k];
        end
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        frame.delete();
        for (int m = 0; m < 2; m++) begin
            m_o[m]   = '0;
            m_v[m]   = 1'b0;
            m_ovr[m] = 1'b0;
        end
    endtask

    task automatic model_update(input bit i, input bit iv, input bit sync, input bit rdy,
                                input bit clr);
        bit           complete = 1'b0;
        bit           free;
        logic [W-1:0] wd[2];
        wd[0] = '0;
        wd[1] = '0;
        if (iv) begin
            hist.push_back(i);
            if (hist.size() > W) void'(hist.pop_front());
            if (sync) begin
                frame.delete();
                frame.push_back(i);
            end else begin
                frame.push_back(i);
                if (frame.size() == W) begin
                    complete = 1'b1;
                    wd[0] = frame_word(1'b1);
                    wd[1] = frame_word(1'b0);
                    frame.delete();
                end
            end
        end else if (sync) begin
            frame.delete();
        end
        for (int m = 0; m < 2; m++) begin
            free = !m_v[m] || rdy;
            if (complete && free) begin
                m_o[m] = wd[m];
                m_v[m] = 1'b1;
            end else if (!complete && m_v[m] && rdy) begin
                m_v[m] = 1'b0;
            end
            if (complete && !free) m_ovr[m] = 1'b1;
            else if (clr)          m_ovr[m] = 1'b0;
        end
    endtask

    task automatic drive(input bit i, input bit iv, input bit sync, input bit rdy, input bit clr);
        if_m.I = i; if_m.I_VALID = iv; if_m.SYNC = sync; if_m.O_READY = rdy;
        if_m.CLR_OVERRUN = clr;
        if_l.I = i; if_l.I_VALID = iv; if_l.SYNC = sync; if_l.O_READY = rdy;
        if_l.CLR_OVERRUN = clr;
    endtask

    // One clock: inputs set 1 time unit after the previous edge, model advanced at the edge.
    task automatic step(input bit i, input bit iv, input bit sync, input bit rdy, input bit clr);
        drive(i, iv, sync, rdy, clr);
        @(posedge CLK);
        model_update(i, iv, sync, rdy, clr);
        #1;
    endtask

    // Byte sent first-bit = b[7]; clr_last raises CLR_OVERRUN only with the final bit.
    task automatic send_byte(input logic [7:0] b, input bit rdy, input bit clr_last);
        for (int k = 7; k >= 0; k--) step(b[k], 1'b1, 1'b0, rdy, clr_last && (k == 0));
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        RESET = 1'b1;
        #1;
        chk("rst_m_shift", if_m.SHIFT, 0);
        chk("rst_m_o", if_m.O, 0);
        chk("rst_m_valid", if_m.O_VALID, 0);
        chk("rst_m_ovr", if_m.OVERRUN, 0);
        chk("rst_l_shift", if_l.SHIFT, 0);
        chk("rst_l_o", if_l.O, 0);
        chk("rst_l_valid", if_l.O_VALID, 0);
        chk("rst_l_ovr", if_l.OVERRUN, 0);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        if (chk_en && !RESET) begin
            chk("m_shift", if_m.SHIFT, shift_model(1'b1));
            chk("m_o", if_m.O, m_o[0]);
            chk("m_valid", if_m.O_VALID, m_v[0]);
            chk("m_ovr", if_m.OVERRUN, m_ovr[0]);
            chk("l_shift", if_l.SHIFT, shift_model(1'b0));
            chk("l_o", if_l.O, m_o[1]);
            chk("l_valid", if_l.O_VALID, m_v[1]);
            chk("l_ovr", if_l.OVERRUN, m_ovr[1]);
        end
    end

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk_en = 1'b1;

        // Back-to-back bits of 0xA5.
        do_reset();
        send_byte(8'hA5, 1'b1, 1'b0);
        chk("a5_m_o", if_m.O, 32'hA5);
        chk("a5_m_valid", if_m.O_VALID, 1);
        chk("a5_m_shift", if_m.SHIFT, 32'hA5);
        chk("a5_m_ovr", if_m.OVERRUN, 0);
        chk("a5_l_o", if_l.O, 32'hA5);
        idle(1'b1);
        chk("a5_valid_once", if_m.O_VALID, 0);
        chk("a5_o_held", if_m.O, 32'hA5);

        // Same word with random idle gaps.
        for (int k = 7; k >= 0; k--) begin
            logic [7:0] b = 8'hA5;
            step(b[k], 1'b1, 1'b0, 1'b1, 1'b0);
            if (k != 0) repeat ($urandom_range(0, 3)) idle(1'b1);
        end
        chk("gap_m_o", if_m.O, 32'hA5);
        chk("gap_m_valid", if_m.O_VALID, 1);
        idle(1'b1);

        // Single leading one: direction decides which end it lands at.
        send_byte(8'h80, 1'b1, 1'b0);
        chk("one_m_o", if_m.O, 32'h80);
        chk("one_l_o", if_l.O, 32'h01);
        idle(1'b1);

        // Realignment: 3 stray bits, then SYNC with the first of 8 ones.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sync_no_early", if_m.O_VALID, 0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sync_m_o", if_m.O, 32'hFF);
        chk("sync_m_valid", if_m.O_VALID, 1);
        idle(1'b1);

        // Overrun: consumer stalled across two frames.
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("ovr_m_o", if_m.O, 32'h11);
        chk("ovr_l_o", if_l.O, 32'h88);
        chk("ovr_m_valid", if_m.O_VALID, 1);
        chk("ovr_m_flag", if_m.OVERRUN, 1);
        idle(1'b1);
        chk("ovr_drain", if_m.O_VALID, 0);
        chk("ovr_sticky", if_m.OVERRUN, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", if_m.OVERRUN, 0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        chk("ovr_again", if_m.OVERRUN, 1);
        send_byte(8'h55, 1'b0, 1'b1);
        chk("ovr_set_wins", if_m.OVERRUN, 1);
        chk("ovr_o_kept", if_m.O, 32'h33);

        // Reset mid-frame while a word is pending, then a clean frame.
        for (int k = 7; k >= 3; k--) begin
            logic [7:0] b = 8'hE7;
            step(b[k], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        do_reset();
        send_byte(8'h3C, 1'b1, 1'b0);
        chk("post_rst_m_o", if_m.O, 32'h3C);
        chk("post_rst_l_o", if_l.O, 32'h3C);
        chk("post_rst_shift", if_m.SHIFT, 32'h3C);
        chk("post_rst_valid", if_m.O_VALID, 1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
